// File: rtl/eva_ahb_pkg.sv
// Shared types and register map for the EVA AHB-Lite register slave.
// Pure definitions: no timing or flow-control behaviour lives here.
package eva_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_e;

    localparam logic [7:0] OFS_ID       = 8'h00;
    localparam logic [7:0] OFS_CTRL     = 8'h04;
    localparam logic [7:0] OFS_INT_RAW  = 8'h08;
    localparam logic [7:0] OFS_INT_MASK = 8'h0C;
    localparam logic [7:0] OFS_INT_STAT = 8'h10;
    localparam logic [7:0] OFS_TICK     = 8'h14;
    localparam logic [7:0] OFS_SCR0     = 8'h20;

    localparam int MAX_SCR = 8;

    // Word offsets only; alignment is checked separately by the caller.
    function automatic logic ofs_mapped(input logic [7:0] ofs, input int nscr);
        logic hit;
        hit = (ofs == OFS_ID) || (ofs == OFS_CTRL) || (ofs == OFS_INT_RAW) ||
              (ofs == OFS_INT_MASK) || (ofs == OFS_INT_STAT) || (ofs == OFS_TICK);
        for (int i = 0; i < MAX_SCR; i++) begin
            if ((i < nscr) && (ofs == OFS_SCR0 + 8'(4 * i))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/eva_irq_ctrl.sv
// Edge-triggered interrupt controller: sticky INT_RAW (set beats W1C), INT_MASK, gated output.
// INT_RAW updates one cycle after an intr_src rising edge; interrupt lags INT_RAW by one cycle; no backpressure.
module eva_irq_ctrl (
    input  logic        hclk,
    input  logic        hrest_n,
    input  logic [31:0] intr_src,
    input  logic        w1c_vld,
    input  logic        mask_we,
    input  logic [31:0] wdat,
    input  logic        irq_en,
    output logic [31:0] int_raw,
    output logic [31:0] int_mask,
    output logic [31:0] interrupt
);

    logic [31:0] intr_ff_q, intr_ff_d;
    logic [31:0] raw_q, raw_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] irq_q, irq_d;
    logic [31:0] edge_c;
    logic [31:0] clr_c;

    always_comb begin
        intr_ff_d = intr_src;
        edge_c    = intr_src & ~intr_ff_q;
        clr_c     = w1c_vld ? wdat : 32'h0;
        // OR-ing the edge after the clear makes a same-cycle set win.
        raw_d     = (raw_q & ~clr_c) | edge_c;
        mask_d    = mask_we ? wdat : mask_q;
        irq_d     = irq_en ? (raw_q & mask_q) : 32'h0;
    end

    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            intr_ff_q <= '0;
            raw_q     <= '0;
            mask_q    <= '0;
            irq_q     <= '0;
        end else begin
            intr_ff_q <= intr_ff_d;
            raw_q     <= raw_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    assign int_raw   = raw_q;
    assign int_mask  = mask_q;
    assign interrupt = irq_q;

endmodule

// File: rtl/eva_ahb_regslv.sv
// AHB-Lite register slave: ID, CTRL, interrupt block, TICK counter and scratch registers.
// Data phase takes 1+WAIT_CYC cycles (2 for ERROR); stalls the bus via hready_out, next address taken on the final cycle.
module eva_ahb_regslv
    import eva_ahb_pkg::*;
#(
    parameter logic [31:0] ID_VAL   = 32'hE7A0_0001,
    parameter int          NSCR     = 4,
    parameter int          WAIT_CYC = 0
) (
    input  logic        hclk,
    input  logic        hrest_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    input  logic [31:0] intr_src,
    output logic [31:0] interrupt
);

    state_e      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic        pend_q, pend_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] tick_q, tick_d;
    logic [31:0] scr_q [NSCR];
    logic [31:0] scr_d [NSCR];

    logic        acc_c;
    logic        acc_err_c;
    logic        hready_c;
    hresp_e      resp_c;
    logic        commit_c;
    logic        wr_c;
    logic        rd_c;
    logic [31:0] rmux_c;
    logic        w1c_vld_c;
    logic        mask_we_c;
    logic [31:0] int_raw;
    logic [31:0] int_mask;
    logic        unused_bits;

    assign unused_bits = ^{haddr[31:8], htrans[0]};

    assign acc_c     = hsel & htrans[1] & hready_in;
    assign acc_err_c = (hsize != 3'b010) || (haddr[1:0] != 2'b00) ||
                       !ofs_mapped(haddr[7:0], NSCR);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        hready_c = 1'b1;
        resp_c   = HRESP_OKAY;
        case (state_q)
            S_IDLE, S_ERR2: begin
                if (state_q == S_ERR2) begin
                    resp_c = HRESP_ERROR;
                end
                state_d = S_IDLE;
                if (acc_c) begin
                    if (acc_err_c) begin
                        state_d = S_ERR1;
                    end else if (WAIT_CYC > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 3'(WAIT_CYC - 1);
                    end
                end
            end
            S_WAIT: begin
                hready_c = 1'b0;
                if (wcnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_ERR1: begin
                hready_c = 1'b0;
                resp_c   = HRESP_ERROR;
                state_d  = S_ERR2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // pend marks an OKAY transfer whose data phase has not yet completed.
    always_comb begin
        addr_d  = acc_c ? haddr[7:0] : addr_q;
        write_d = acc_c ? hwrite : write_q;
        pend_d  = pend_q;
        if (acc_c) begin
            pend_d = ~acc_err_c;
        end else if (hready_c) begin
            pend_d = 1'b0;
        end
    end

    assign commit_c = pend_q && (state_q == S_IDLE);
    assign wr_c     = commit_c & write_q;
    assign rd_c     = commit_c & ~write_q;

    always_comb begin
        ctrl_d    = ctrl_q;
        scr_d     = scr_q;
        tick_d    = tick_q + 32'd1;
        rmux_c    = 32'h0;
        w1c_vld_c = 1'b0;
        mask_we_c = 1'b0;
        case (addr_q)
            OFS_ID:       rmux_c = ID_VAL;
            OFS_CTRL: begin
                rmux_c = ctrl_q;
                if (wr_c) begin
                    ctrl_d = hwdata;
                end
            end
            OFS_INT_RAW: begin
                rmux_c    = int_raw;
                w1c_vld_c = wr_c;
            end
            OFS_INT_MASK: begin
                rmux_c    = int_mask;
                mask_we_c = wr_c;
            end
            OFS_INT_STAT: rmux_c = int_raw & int_mask;
            OFS_TICK:     rmux_c = tick_q;
            default: begin
                for (int i = 0; i < NSCR; i++) begin
                    if (addr_q == OFS_SCR0 + 8'(4 * i)) begin
                        rmux_c = scr_q[i];
                        if (wr_c) begin
                            scr_d[i] = hwdata;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            pend_q  <= 1'b0;
            ctrl_q  <= '0;
            tick_q  <= '0;
            for (int i = 0; i < NSCR; i++) begin
                scr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            pend_q  <= pend_d;
            ctrl_q  <= ctrl_d;
            tick_q  <= tick_d;
            scr_q   <= scr_d;
        end
    end

    eva_irq_ctrl u_irq (
        .hclk      (hclk),
        .hrest_n   (hrest_n),
        .intr_src  (intr_src),
        .w1c_vld   (w1c_vld_c),
        .mask_we   (mask_we_c),
        .wdat      (hwdata),
        .irq_en    (ctrl_q[0]),
        .int_raw   (int_raw),
        .int_mask  (int_mask),
        .interrupt (interrupt)
    );

    assign hready_out = hready_c;
    assign hresp      = resp_c;
    assign hrdata     = rd_c ? rmux_c : 32'h0;

endmodule

// File: tb/tb_eva_ahb_regslv.sv
// Bench for eva_ahb_regslv: directed scenarios plus randomized pipelined traffic vs a register-map model.
module tb_eva_ahb_regslv;

    localparam logic [31:0] ID   = 32'hE7A0_0001;
    localparam int          NSCR = 4;
    localparam int          WAIT = 2;

    logic        hclk;
    logic        hrest_n;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [31:0] intr_src;
    logic [31:0] interrupt;
    wire         hready_loop = hready_out;

    int checks = 0;
    int errors = 0;

    eva_ahb_regslv #(.ID_VAL(ID), .NSCR(NSCR), .WAIT_CYC(WAIT)) dut (
        .hclk       (hclk),
        .hrest_n    (hrest_n),
        .hsel       (hsel),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hready_in  (hready_loop),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .intr_src   (intr_src),
        .interrupt  (interrupt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference: clock edges seen since reset release.
    logic [31:0] tb_tick;
    always @(posedge hclk or negedge hrest_n) begin
        if (!hrest_n) tb_tick <= 32'h0;
        else          tb_tick <= tb_tick + 32'h1;
    end

    // Register-map model.
    logic [31:0] m_ctrl, m_raw, m_mask;
    logic [31:0] m_scr [NSCR];

    // Transfer list for the pipelined driver and per-transfer observations.
    logic [31:0] p_addr [8];
    logic        p_wr   [8];
    logic [2:0]  p_size [8];
    logic [31:0] p_wdat [8];
    logic [31:0] r_dat  [8];
    logic [1:0]  r_resp [8];
    logic [1:0]  r_wresp[8];
    int          r_wait [8];
    logic [31:0] r_tk   [8];

    logic [7:0] ofs_tbl [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h3C, 8'h40, 8'h22};

    function automatic bit m_mapped(input logic [7:0] a);
        if (a inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14}) return 1'b1;
        return (a >= 8'h20) && (int'(a) < 32 + 4 * NSCR) && (a[1:0] == 2'b00);
    endfunction

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
        return (sz != 3'd2) || (a[1:0] != 2'b00) || !m_mapped(a[7:0]);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic [31:0] tk);
        case (a)
            8'h00:   return ID;
            8'h04:   return m_ctrl;
            8'h08:   return m_raw;
            8'h0C:   return m_mask;
            8'h10:   return m_raw & m_mask;
            8'h14:   return tk;
            default: return m_scr[(int'(a) - 32) / 4];
        endcase
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h04: m_ctrl = d;
            8'h08: m_raw  = m_raw & ~d;
            8'h0C: m_mask = d;
            8'h00, 8'h10, 8'h14: ;
            default: m_scr[(int'(a) - 32) / 4] = d;
        endcase
    endtask

    task automatic m_clear();
        m_ctrl = 0; m_raw = 0; m_mask = 0;
        for (int i = 0; i < NSCR; i++) m_scr[i] = 0;
    endtask

    task automatic step();
        @(posedge hclk); #1;
    endtask

    task automatic drive_addr(input int k);
        hsel = 1'b1; htrans = 2'b10; haddr = p_addr[k]; hwrite = p_wr[k]; hsize = p_size[k];
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
    endtask

    task automatic set_op(input int k, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d);
        p_wr[k] = wr; p_addr[k] = a; p_size[k] = sz; p_wdat[k] = d;
    endtask

    // Runs n transfers back-to-back; call just after a rising edge while the bus is idle.
    // edge_mask is OR-ed into intr_src during the last transfer's final data cycle.
    task automatic run_pipe(input int n, input logic [31:0] edge_mask);
        drive_addr(0);
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            step();
            hwdata = p_wdat[k];
            if (k + 1 < n) drive_addr(k + 1);
            else           drive_idle();
            r_wresp[k] = 2'b00;
            @(negedge hclk);
            while (hready_out !== 1'b1 && w < 20) begin
                if (w == 0) r_wresp[k] = hresp;
                w++;
                @(negedge hclk);
            end
            if (w >= 20) begin
                checks++; errors++;
                $display("FAIL hready_timeout: op %0d hready_out=%b required 1", k, hready_out);
            end
            r_wait[k] = w; r_dat[k] = hrdata; r_resp[k] = hresp; r_tk[k] = tb_tick;
            if (k == n - 1) intr_src = intr_src | edge_mask;
        end
        step();
        hwdata = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge hclk);
        checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL rst_hready: got %b required 1", hready_out); end
        checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL rst_hresp: got %b required 00", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h required 0", hrdata); end
        checks++; if (interrupt !== 32'h0) begin errors++; $display("FAIL rst_interrupt: got %h required 0", interrupt); end
        hrest_n = 1'b1;
        m_clear();
        step();
        set_op(0, 1'b0, 32'h0, 3'd2, 32'h0);
        run_pipe(1, 32'h0);
        checks++; if (r_dat[0] !== ID) begin errors++; $display("FAIL id_read: got %h required %h", r_dat[0], ID); end
        checks++; if (r_resp[0] !== 2'b00) begin errors++; $display("FAIL id_resp: got %b required 00", r_resp[0]); end
        checks++; if (r_wait[0] != WAIT) begin errors++; $display("FAIL id_waits: got %0d required %0d", r_wait[0], WAIT); end
    endtask

    task automatic test_tick();
        set_op(0, 1'b0, 32'h14, 3'd2, 32'h0);
        set_op(1, 1'b0, 32'h14, 3'd2, 32'h0);
        run_pipe(2, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (r_dat[k] !== r_tk[k]) begin errors++; $display("FAIL tick_abs: got %h required %h", r_dat[k], r_tk[k]); end
        end
        checks++;
        if (r_dat[1] - r_dat[0] !== 32'(WAIT + 1)) begin
            errors++; $display("FAIL tick_delta: got %0d required %0d", r_dat[1] - r_dat[0], WAIT + 1);
        end
    endtask

    task automatic test_back_to_back();
        set_op(0, 1'b1, 32'h20, 3'd2, 32'hDEAD_BEEF);
        set_op(1, 1'b0, 32'h20, 3'd2, 32'h0);
        run_pipe(2, 32'h0);
        m_write(8'h20, 32'hDEAD_BEEF);
        for (int k = 0; k < 2; k++) begin
            checks++; if (r_wait[k] != WAIT) begin errors++; $display("FAIL b2b_waits: op %0d got %0d required %0d", k, r_wait[k], WAIT); end
        end
        checks++; if (r_dat[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_raw: got %h required deadbeef", r_dat[1]); end
    endtask

    task automatic test_errors();
        set_op(0, 1'b0, 32'h40, 3'd2, 32'h0);
        set_op(1, 1'b1, 32'h04, 3'd0, 32'h1);
        set_op(2, 1'b0, 32'h04, 3'd2, 32'h0);
        run_pipe(3, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (r_wait[k] != 1) begin errors++; $display("FAIL err_waits: op %0d got %0d required 1", k, r_wait[k]); end
            checks++; if (r_wresp[k] !== 2'b01) begin errors++; $display("FAIL err_resp1: op %0d got %b required 01", k, r_wresp[k]); end
            checks++; if (r_resp[k] !== 2'b01) begin errors++; $display("FAIL err_resp2: op %0d got %b required 01", k, r_resp[k]); end
            checks++; if (r_dat[k] !== 32'h0) begin errors++; $display("FAIL err_rdata: op %0d got %h required 0", k, r_dat[k]); end
        end
        checks++; if (r_dat[2] !== m_ctrl) begin errors++; $display("FAIL err_ctrl: got %h required %h", r_dat[2], m_ctrl); end
    endtask

    task automatic test_irq();
        set_op(0, 1'b1, 32'h0C, 3'd2, 32'h1);
        set_op(1, 1'b1, 32'h04, 3'd2, 32'h1);
        run_pipe(2, 32'h0);
        m_write(8'h0C, 32'h1); m_write(8'h04, 32'h1);
        intr_src = 32'h1; step(); intr_src = 32'h0;
        m_raw = m_raw | 32'h1;
        @(negedge hclk);
        checks++; if (interrupt !== 32'h0) begin errors++; $display("FAIL irq_lag: got %h required 0", interrupt); end
        step(); @(negedge hclk);
        checks++; if (interrupt !== 32'h1) begin errors++; $display("FAIL irq_set: got %h required 1", interrupt); end
        step();
        set_op(0, 1'b0, 32'h08, 3'd2, 32'h0);
        set_op(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run_pipe(2, 32'h0);
        checks++; if (r_dat[0] !== m_raw) begin errors++; $display("FAIL irq_raw: got %h required %h", r_dat[0], m_raw); end
        checks++; if (r_dat[1] !== (m_raw & m_mask)) begin errors++; $display("FAIL irq_stat: got %h required %h", r_dat[1], m_raw & m_mask); end
        set_op(0, 1'b1, 32'h08, 3'd2, 32'h1);
        run_pipe(1, 32'h0);
        m_write(8'h08, 32'h1);
        step(); @(negedge hclk);
        checks++; if (interrupt !== 32'h0) begin errors++; $display("FAIL irq_w1c: got %h required 0", interrupt); end
        step();
        intr_src = 32'h2; step(); intr_src = 32'h0;
        m_raw = m_raw | 32'h2;
        step(); @(negedge hclk);
        checks++; if (interrupt !== 32'h0) begin errors++; $display("FAIL irq_masked: got %h required 0", interrupt); end
        step();
        set_op(0, 1'b0, 32'h08, 3'd2, 32'h0);
        run_pipe(1, 32'h0);
        checks++; if (r_dat[0] !== m_raw) begin errors++; $display("FAIL irq_raw1: got %h required %h", r_dat[0], m_raw); end
    endtask

    task automatic test_set_wins();
        intr_src = 32'h1; step(); intr_src = 32'h0; step();
        m_raw = m_raw | 32'h1;
        set_op(0, 1'b1, 32'h08, 3'd2, 32'h1);
        run_pipe(1, 32'h1);
        intr_src = 32'h0;
        m_raw = (m_raw & ~32'h1) | 32'h1;
        set_op(0, 1'b0, 32'h08, 3'd2, 32'h0);
        run_pipe(1, 32'h0);
        checks++; if (r_dat[0] !== m_raw) begin errors++; $display("FAIL set_wins: got %h required %h", r_dat[0], m_raw); end
        @(negedge hclk);
        checks++;
        if (interrupt !== (m_ctrl[0] ? (m_raw & m_mask) : 32'h0)) begin
            errors++; $display("FAIL set_wins_irq: got %h required %h", interrupt, m_raw & m_mask);
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_op(0, 1'b1, 32'h24, 3'd2, 32'h1234_5678);
        drive_addr(0);
        step();
        hwdata = p_wdat[0];
        drive_idle();
        @(negedge hclk);
        checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL mid_wait: got %b required 0", hready_out); end
        hrest_n = 1'b0;
        #1;
        checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL mid_hready: got %b required 1", hready_out); end
        checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL mid_hresp: got %b required 00", hresp); end
        checks++; if (interrupt !== 32'h0) begin errors++; $display("FAIL mid_irq: got %h required 0", interrupt); end
        hwdata = 32'h0;
        step(); step();
        @(negedge hclk);
        hrest_n = 1'b1;
        m_clear();
        step();
        set_op(0, 1'b0, 32'h24, 3'd2, 32'h0);
        set_op(1, 1'b0, 32'h0C, 3'd2, 32'h0);
        run_pipe(2, 32'h0);
        checks++; if (r_dat[0] !== 32'h0) begin errors++; $display("FAIL mid_scr1: got %h required 0", r_dat[0]); end
        checks++; if (r_dat[1] !== 32'h0) begin errors++; $display("FAIL mid_mask: got %h required 0", r_dat[1]); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            int n;
            n = int'($urandom_range(2, 6));
            for (int k = 0; k < n; k++) begin
                p_addr[k] = ($urandom() & 32'hFFFF_FF00) | {24'h0, ofs_tbl[$urandom_range(0, 15)]};
                p_wr[k]   = 1'($urandom_range(0, 1));
                p_size[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
                p_wdat[k] = $urandom();
            end
            run_pipe(n, 32'h0);
            for (int k = 0; k < n; k++) begin
                bit e;
                logic [31:0] exp_d;
                e = m_err(p_addr[k], p_size[k]);
                exp_d = (e || p_wr[k]) ? 32'h0 : m_read(p_addr[k][7:0], r_tk[k]);
                checks++;
                if (r_wait[k] != (e ? 1 : WAIT)) begin
                    errors++; $display("FAIL rnd_waits: addr %h got %0d required %0d", p_addr[k], r_wait[k], e ? 1 : WAIT);
                end
                checks++;
                if (r_resp[k] !== (e ? 2'b01 : 2'b00) || r_wresp[k] !== (e ? 2'b01 : 2'b00)) begin
                    errors++; $display("FAIL rnd_resp: addr %h got %b/%b required %b", p_addr[k], r_wresp[k], r_resp[k], e ? 2'b01 : 2'b00);
                end
                checks++;
                if (r_dat[k] !== exp_d) begin
                    errors++; $display("FAIL rnd_rdata: addr %h wr %b got %h required %h", p_addr[k], p_wr[k], r_dat[k], exp_d);
                end
                if (!e && p_wr[k]) m_write(p_addr[k][7:0], p_wdat[k]);
            end
        end
        step(); step();
        @(negedge hclk);
        checks++;
        if (interrupt !== (m_ctrl[0] ? (m_raw & m_mask) : 32'h0)) begin
            errors++; $display("FAIL rnd_irq: got %h required %h", interrupt, m_ctrl[0] ? (m_raw & m_mask) : 32'h0);
        end
    endtask

    initial begin
        hrest_n  = 1'b0;
        intr_src = 32'h0;
        hwdata   = 32'h0;
        drive_idle();
        repeat (3) @(posedge hclk);
        test_reset();
        test_tick();
        test_back_to_back();
        test_errors();
        test_irq();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
